// File: rtl/cheshire_idma_launcher_pkg.sv
// ============================================================================
// Module   : cheshire_idma_launcher_pkg
// Brief    : Register map, FSM states and register-bus types for the launcher.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cheshire_idma_launcher_pkg;

   localparam logic [31:0] c_off_conf    = 32'h0000_0000;
   localparam logic [31:0] c_off_next_id = 32'h0000_0010;
   localparam logic [31:0] c_off_done_id = 32'h0000_0018;
   localparam logic [31:0] c_off_dst_lo  = 32'h0000_00D0;
   localparam logic [31:0] c_off_dst_hi  = 32'h0000_00D4;
   localparam logic [31:0] c_off_src_lo  = 32'h0000_00D8;
   localparam logic [31:0] c_off_src_hi  = 32'h0000_00DC;
   localparam logic [31:0] c_off_len     = 32'h0000_00E0;

   typedef enum logic [3:0] {
      IDLE,
      WR_DST_LO,
      WR_DST_HI,
      WR_SRC_LO,
      WR_SRC_HI,
      WR_LEN,
      WR_CONF,
      RD_NEXT,
      POLL_WAIT,
      RD_DONE,
      REPORT
   } launcher_state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } launcher_reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } launcher_reg_rsp_t;

endpackage

`default_nettype wire

// File: rtl/cheshire_idma_launcher.sv
// ============================================================================
// Module   : cheshire_idma_launcher
// Brief    : Programs one iDMA job over the register bus, polls for completion.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cheshire_idma_launcher
   import cheshire_idma_launcher_pkg::*;
#(
   parameter int unsigned AddrWidth   = 64,
   parameter logic [31:0] RegBaseAddr = 32'h0,
   parameter int unsigned PollWait    = 8,
   parameter type         reg_req_t   = cheshire_idma_launcher_pkg::launcher_reg_req_t,
   parameter type         reg_rsp_t   = cheshire_idma_launcher_pkg::launcher_reg_rsp_t
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [AddrWidth-1:0] job_src_i,
   input  logic [AddrWidth-1:0] job_dst_i,
   input  logic [31:0]          job_len_i,
   input  logic                 job_valid_i,
   output logic                 job_ready_o,
   output reg_req_t             reg_req_o,
   input  reg_rsp_t             reg_rsp_i,
   output logic                 done_valid_o,
   output logic [31:0]          done_id_o,
   output logic                 done_err_o,
   output logic                 busy_o
);

   localparam bit          HAS_HI = (AddrWidth > 32);
   localparam int unsigned CNT_W  = (PollWait > 1) ? $clog2(PollWait) : 1;

   launcher_state_e r_state, w_state_next;

   logic [63:0]      r_src, r_dst;
   logic [31:0]      r_len, r_job_id;
   logic             r_err;
   logic [CNT_W-1:0] r_poll_cnt, w_cnt_next;

   logic             w_access, w_write, w_err_set, w_id_load;
   logic [31:0]      w_off, w_wdata, w_diff;

   // Serial-number distance: the job is done once DONE_ID is at or past our id.
   assign w_diff = reg_rsp_i.rdata - r_job_id;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_poll_cnt;
      w_access     = 1'b0;
      w_write      = 1'b0;
      w_off        = '0;
      w_wdata      = '0;
      w_id_load    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (job_valid_i) w_state_next = WR_DST_LO;
         end
         WR_DST_LO: begin
            w_access = 1'b1; w_write = 1'b1; w_off = c_off_dst_lo; w_wdata = r_dst[31:0];
            if (reg_rsp_i.ready) w_state_next = HAS_HI ? WR_DST_HI : WR_SRC_LO;
         end
         WR_DST_HI: begin
            w_access = 1'b1; w_write = 1'b1; w_off = c_off_dst_hi; w_wdata = r_dst[63:32];
            if (reg_rsp_i.ready) w_state_next = WR_SRC_LO;
         end
         WR_SRC_LO: begin
            w_access = 1'b1; w_write = 1'b1; w_off = c_off_src_lo; w_wdata = r_src[31:0];
            if (reg_rsp_i.ready) w_state_next = HAS_HI ? WR_SRC_HI : WR_LEN;
         end
         WR_SRC_HI: begin
            w_access = 1'b1; w_write = 1'b1; w_off = c_off_src_hi; w_wdata = r_src[63:32];
            if (reg_rsp_i.ready) w_state_next = WR_LEN;
         end
         WR_LEN: begin
            w_access = 1'b1; w_write = 1'b1; w_off = c_off_len; w_wdata = r_len;
            if (reg_rsp_i.ready) w_state_next = WR_CONF;
         end
         WR_CONF: begin
            w_access = 1'b1; w_write = 1'b1; w_off = c_off_conf;
            if (reg_rsp_i.ready) w_state_next = RD_NEXT;
         end
         RD_NEXT: begin
            w_access = 1'b1; w_off = c_off_next_id;
            if (reg_rsp_i.ready) begin
               w_id_load    = 1'b1;
               w_state_next = reg_rsp_i.error ? REPORT : POLL_WAIT;
            end
         end
         POLL_WAIT: begin
            if (PollWait == 0 || r_poll_cnt == CNT_W'(PollWait - 1)) begin
               w_cnt_next   = '0;
               w_state_next = RD_DONE;
            end else begin
               w_cnt_next = r_poll_cnt + CNT_W'(1);
            end
         end
         RD_DONE: begin
            w_access = 1'b1; w_off = c_off_done_id;
            if (reg_rsp_i.ready) begin
               if (reg_rsp_i.error || $signed(w_diff) >= 32'sd0) w_state_next = REPORT;
               else                                               w_state_next = POLL_WAIT;
            end
         end
         REPORT: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign w_err_set = w_access & reg_rsp_i.ready & reg_rsp_i.error;

   always_comb begin
      reg_req_o       = '0;
      reg_req_o.addr  = RegBaseAddr + w_off;
      reg_req_o.write = w_write;
      reg_req_o.wdata = w_wdata;
      reg_req_o.wstrb = w_write ? 4'hF : 4'h0;
      reg_req_o.valid = w_access;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_src      <= '0;
         r_dst      <= '0;
         r_len      <= '0;
         r_job_id   <= '0;
         r_err      <= 1'b0;
         r_poll_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_poll_cnt <= w_cnt_next;
         if (r_state == IDLE && job_valid_i) begin
            r_src <= 64'(job_src_i);
            r_dst <= 64'(job_dst_i);
            r_len <= job_len_i;
         end
         if (w_id_load) r_job_id <= reg_rsp_i.rdata;
         if (r_state == REPORT) r_err <= 1'b0;
         else if (w_err_set)    r_err <= 1'b1;
      end
   end

   assign job_ready_o  = (r_state == IDLE);
   assign busy_o       = (r_state != IDLE);
   assign done_valid_o = (r_state == REPORT);
   assign done_id_o    = done_valid_o ? r_job_id : 32'h0;
   assign done_err_o   = done_valid_o & r_err;

endmodule

`default_nettype wire

// File: tb/tb_cheshire_idma_launcher.sv
// ============================================================================
// Module   : tb_cheshire_idma_launcher
// Brief    : Self-checking bench with a transaction-level model of the launcher.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cheshire_idma_launcher;
   import cheshire_idma_launcher_pkg::*;

   localparam int unsigned AW   = 64;
   localparam int unsigned PW   = 3;
   localparam logic [31:0] BASE = 32'h0300_0000;
   localparam logic [31:0] B1   = 32'h0000_1000;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } acc_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [AW-1:0]     job_src = '0, job_dst = '0;
   logic [31:0]       job_len = '0;
   logic              job_valid = 1'b0, job_ready;
   launcher_reg_req_t req;
   launcher_reg_rsp_t rsp = '0;
   logic              done_valid, done_err, busy;
   logic [31:0]       done_id;

   logic [31:0]       j1_src = 32'hA000_0000, j1_dst = 32'hB000_0000, j1_len = 32'h40;
   logic              j1_valid = 1'b0, j1_ready;
   launcher_reg_req_t req1;
   launcher_reg_rsp_t rsp1 = '0;
   logic              d1_valid, d1_err, busy1;
   logic [31:0]       d1_id;

   always #5 clk = ~clk;

   cheshire_idma_launcher #(
      .AddrWidth(AW), .RegBaseAddr(BASE), .PollWait(PW),
      .reg_req_t(launcher_reg_req_t), .reg_rsp_t(launcher_reg_rsp_t)
   ) u_dut (
      .clk_i(clk), .rst_i(rst), .job_src_i(job_src), .job_dst_i(job_dst), .job_len_i(job_len),
      .job_valid_i(job_valid), .job_ready_o(job_ready), .reg_req_o(req), .reg_rsp_i(rsp),
      .done_valid_o(done_valid), .done_id_o(done_id), .done_err_o(done_err), .busy_o(busy)
   );

   cheshire_idma_launcher #(
      .AddrWidth(32), .RegBaseAddr(B1), .PollWait(0),
      .reg_req_t(launcher_reg_req_t), .reg_rsp_t(launcher_reg_rsp_t)
   ) u_dut32 (
      .clk_i(clk), .rst_i(rst), .job_src_i(j1_src), .job_dst_i(j1_dst), .job_len_i(j1_len),
      .job_valid_i(j1_valid), .job_ready_o(j1_ready), .reg_req_o(req1), .reg_rsp_i(rsp1),
      .done_valid_o(d1_valid), .done_id_o(d1_id), .done_err_o(d1_err), .busy_o(busy1)
   );

   int n_cmp = 0, n_fail = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic acc_t mk(logic we, logic [31:0] ad, logic [31:0] da);
      acc_t r;
      r.we = we; r.addr = ad; r.data = da;
      return r;
   endfunction

   // Model state: what the launcher still owes the bus, and what it must report.
   acc_t        m_q[$];
   int          m_gap = 0;
   bit          m_busy = 0, m_rep = 0, m_err = 0;
   logic [31:0] m_id = '0;
   int          poll_lag = 0;

   bit          want_job = 0, rand_jobs = 0, rnd_rdy = 0, err_rand = 0, do_rst = 0, err_once = 0;
   logic [63:0] d_src, d_dst;
   logic [31:0] d_len, stall_addr = '0, err_addr = '0;
   int          stall_left = 0;
   logic [31:0] next_q[$], done_q[$];

   int          cyc = 0, rep_cnt = 0;
   logic [31:0] last_id = '0;
   logic        last_err = 1'b0;
   acc_t        log_q[$];
   int          poll_cyc[$];

   function automatic logic [31:0] poll_value();
      logic [31:0] v;
      if (poll_lag > 0) begin
         v = m_id - 32'(poll_lag);
         poll_lag--;
      end else begin
         v = m_id + 32'($urandom_range(0, 2));
      end
      return v;
   endfunction

   task automatic cycle();
      bit          hs, e, rep_next;
      logic [31:0] rd;
      acc_t        a;
      @(negedge clk);
      cyc++;
      chk("busy", busy, m_busy);
      chk("job_ready", job_ready, !m_busy);
      chk("done_valid", done_valid, m_rep);
      if (m_rep) begin
         chk("done_id", done_id, m_id);
         chk("done_err", done_err, m_err);
         rep_cnt++;
         last_id  = done_id;
         last_err = done_err;
      end
      chk("req_valid", req.valid, m_q.size() > 0);
      if (m_q.size() > 0 && req.valid) begin
         a = m_q[0];
         chk("req_write", req.write, a.we);
         chk("req_addr", req.addr, a.addr);
         if (a.we) begin
            chk("req_wdata", req.wdata, a.data);
            chk("req_wstrb", req.wstrb, 4'hF);
         end
      end

      rst         = do_rst;
      hs          = 0;
      e           = 0;
      rd          = $urandom;
      rsp.ready   = 1'($urandom_range(0, 1));
      rsp.error   = 1'($urandom_range(0, 1));
      rsp.rdata   = $urandom;
      if (do_rst) begin
         do_rst    = 0;
         job_valid = 1'b0;
         m_q.delete();
         m_gap = 0; m_busy = 0; m_rep = 0; m_err = 0; m_id = '0;
         return;
      end

      if (m_q.size() > 0 && req.valid) begin
         a  = m_q[0];
         hs = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (stall_left > 0 && a.addr == stall_addr) begin
            hs = 0;
            stall_left--;
         end
         if (hs) begin
            e = err_rand && ($urandom_range(0, 15) == 0);
            if (err_once && a.addr == err_addr) begin
               e        = 1;
               err_once = 0;
            end
            if (a.addr == BASE + c_off_next_id) begin
               if (next_q.size() > 0) rd = next_q.pop_front();
               else rd = $urandom_range(0, 1) ? $urandom : (32'hFFFF_FFFF - 32'($urandom_range(0, 3)));
            end else if (a.addr == BASE + c_off_done_id) begin
               if (done_q.size() > 0) rd = done_q.pop_front();
               else rd = poll_value();
            end
         end
         rsp.ready = hs;
         rsp.error = e;
         rsp.rdata = rd;
      end

      if (want_job) begin
         job_valid = 1'b1; job_src = d_src; job_dst = d_dst; job_len = d_len;
      end else begin
         job_valid = rand_jobs ? 1'($urandom_range(0, 1)) : 1'b0;
         job_src   = {$urandom, $urandom};
         job_dst   = {$urandom, $urandom};
         job_len   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      end

      rep_next = 0;
      if (hs) begin
         a = m_q.pop_front();
         log_q.push_back(mk(a.we, a.addr, a.we ? a.data : rd));
         if (e) m_err = 1;
         if (a.addr == BASE + c_off_next_id) begin
            m_id     = rd;
            poll_lag = $urandom_range(0, 3);
            if (e) rep_next = 1;
            else   m_gap = (PW == 0) ? 1 : int'(PW);
         end else if (a.addr == BASE + c_off_done_id) begin
            poll_cyc.push_back(cyc);
            if (e || (rd - m_id) < 32'h8000_0000) rep_next = 1;
            else m_gap = (PW == 0) ? 1 : int'(PW);
         end
      end else if (m_q.size() == 0 && m_gap > 0) begin
         m_gap--;
         if (m_gap == 0) m_q.push_back(mk(1'b0, BASE + c_off_done_id, 32'h0));
      end

      if (m_rep) begin
         m_rep  = 0;
         m_busy = 0;
      end else if (!m_busy && job_valid) begin
         m_busy   = 1;
         m_err    = 0;
         want_job = 0;
         m_q.push_back(mk(1'b1, BASE + c_off_dst_lo, job_dst[31:0]));
         if (AW == 64) m_q.push_back(mk(1'b1, BASE + c_off_dst_hi, job_dst[63:32]));
         m_q.push_back(mk(1'b1, BASE + c_off_src_lo, job_src[31:0]));
         if (AW == 64) m_q.push_back(mk(1'b1, BASE + c_off_src_hi, job_src[63:32]));
         m_q.push_back(mk(1'b1, BASE + c_off_len, job_len));
         m_q.push_back(mk(1'b1, BASE + c_off_conf, 32'h0));
         m_q.push_back(mk(1'b0, BASE + c_off_next_id, 32'h0));
      end
      if (rep_next) m_rep = 1;
   endtask

   task automatic run_job(string tag, logic [63:0] s, logic [63:0] d, logic [31:0] l);
      int start;
      start = rep_cnt;
      d_src = s; d_dst = d; d_len = l; want_job = 1;
      log_q.delete();
      poll_cyc.delete();
      for (int i = 0; i < 400 && rep_cnt == start; i++) cycle();
      if (rep_cnt == start) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: no done_valid_o within 400 cycles, required one report", tag);
      end
      cycle();
   endtask

   // Independent always-ready responder for the 32-bit, zero-wait instance.
   logic [31:0] log1_addr[$], log1_data[$];
   int          poll1_cyc[$];
   int          cyc1 = 0, d1_cnt = 0;
   logic [31:0] d1_last_id = '0;
   logic        d1_last_err = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         cyc1++;
         if (d1_valid) begin
            d1_cnt++;
            d1_last_id  = d1_id;
            d1_last_err = d1_err;
         end
         rsp1 = '0;
         if (req1.valid) begin
            log1_addr.push_back(req1.addr);
            log1_data.push_back(req1.wdata);
            rsp1.ready = 1'b1;
            if (req1.addr == B1 + c_off_next_id) rsp1.rdata = 32'h11;
            else if (req1.addr == B1 + c_off_done_id) begin
               poll1_cyc.push_back(cyc1);
               rsp1.rdata = (poll1_cyc.size() == 1) ? 32'h10 : 32'h11;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   logic [31:0] s64_off  [8] = '{32'hD0, 32'hD4, 32'hD8, 32'hDC, 32'hE0, 32'h00, 32'h10, 32'h18};
   logic [31:0] s28_data [8] = '{32'h2000_0040, 32'h1, 32'h1000_0000, 32'h8000_0000,
                                 32'h100, 32'h0, 32'h7, 32'h7};
   logic [31:0] s32_off  [7] = '{32'hD0, 32'hD8, 32'hE0, 32'h00, 32'h10, 32'h18, 32'h18};
   logic [31:0] s32_data [4] = '{32'hB000_0000, 32'hA000_0000, 32'h40, 32'h0};

   initial begin
      int start;
      do_rst = 1;
      cycle();
      chk("rst_job_ready", job_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_req_valid", req.valid, 1'b0);
      chk("rst_done_valid", done_valid, 1'b0);
      chk("rst_done_id", done_id, 32'h0);
      chk("rst_done_err", done_err, 1'b0);
      cycle();
      j1_valid = 1'b1;
      cycle();
      j1_valid = 1'b0;

      // Full 64-bit descriptor programming order and values
      next_q.push_back(32'h7);
      done_q.push_back(32'h7);
      run_job("s28", 64'h8000_0000_1000_0000, 64'h0000_0001_2000_0040, 32'd256);
      chk("s28_log_size", log_q.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < log_q.size()) begin
            chk("s28_addr", log_q[i].addr, BASE + s64_off[i]);
            chk("s28_data", log_q[i].data, s28_data[i]);
         end
      end

      // 32-bit instance: HI writes skipped, zero poll wait
      chk("s32_log_size", log1_addr.size(), 7);
      for (int i = 0; i < 7; i++) begin
         if (i < log1_addr.size()) chk("s32_addr", log1_addr[i], B1 + s32_off[i]);
         if (i < 4 && i < log1_data.size()) chk("s32_data", log1_data[i], s32_data[i]);
      end
      chk("s32_polls", poll1_cyc.size(), 2);
      if (poll1_cyc.size() == 2) chk("s32_spacing", poll1_cyc[1] - poll1_cyc[0], 2);
      chk("s32_done_cnt", d1_cnt, 1);
      chk("s32_done_id", d1_last_id, 32'h11);
      chk("s32_done_err", d1_last_err, 1'b0);

      // Three polls before completion
      next_q.push_back(32'd5);
      done_q.push_back(32'd3); done_q.push_back(32'd4); done_q.push_back(32'd5);
      run_job("s29", 64'h10, 64'h20, 32'd64);
      chk("s29_polls", poll_cyc.size(), 3);
      for (int i = 1; i < 3; i++)
         if (i < poll_cyc.size()) chk("s29_spacing", poll_cyc[i] - poll_cyc[i-1], 4);
      chk("s29_done_id", last_id, 32'd5);
      chk("s29_done_err", last_err, 1'b0);

      // Id counter wrap
      next_q.push_back(32'hFFFF_FFFF);
      done_q.push_back(32'hFFFF_FFFE); done_q.push_back(32'h0);
      run_job("s30", 64'h1000, 64'h2000, 32'd0);
      chk("s30_polls", poll_cyc.size(), 2);
      chk("s30_done_id", last_id, 32'hFFFF_FFFF);

      // Ten-cycle stall on SRC_LO
      stall_addr = BASE + c_off_src_lo;
      stall_left = 10;
      next_q.push_back(32'h9);
      done_q.push_back(32'h9);
      run_job("s31", 64'hDEAD_BEEF_0000_1111, 64'hCAFE_F00D_0000_2222, 32'd12);
      chk("s31_stall_used", stall_left, 0);
      chk("s31_log_size", log_q.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < log_q.size()) chk("s31_addr", log_q[i].addr, BASE + s64_off[i]);

      // Error on LEN is sticky for that job only
      err_addr = BASE + c_off_len;
      err_once = 1;
      next_q.push_back(32'h1);
      done_q.push_back(32'h1);
      run_job("s32a", 64'h3000, 64'h4000, 32'd8);
      chk("s32a_done_err", last_err, 1'b1);
      chk("s32a_log_size", log_q.size(), 8);
      next_q.push_back(32'h2);
      done_q.push_back(32'h2);
      run_job("s32b", 64'h5000, 64'h6000, 32'd8);
      chk("s32b_done_err", last_err, 1'b0);

      // Reset while waiting between polls
      next_q.push_back(32'h20);
      done_q.push_back(32'h20);
      d_src = 64'h7000; d_dst = 64'h8000; d_len = 32'd4; want_job = 1;
      for (int i = 0; i < 100 && !(m_busy && m_q.size() == 0 && m_gap > 0); i++) cycle();
      chk("s33_in_poll_wait", m_busy && m_q.size() == 0 && m_gap > 0, 1'b1);
      start = rep_cnt;
      do_rst = 1;
      cycle();
      cycle();
      chk("s33_job_ready", job_ready, 1'b1);
      chk("s33_busy", busy, 1'b0);
      chk("s33_req_valid", req.valid, 1'b0);
      chk("s33_done_valid", done_valid, 1'b0);
      repeat (10) cycle();
      chk("s33_no_report", rep_cnt, start);
      next_q.delete();
      done_q.delete();

      // Randomized traffic with stalls, errors, wrap-biased ids and rare resets
      rand_jobs = 1; rnd_rdy = 1; err_rand = 1;
      start = rep_cnt;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) do_rst = 1;
         cycle();
      end
      chk("rand_reports_seen", (rep_cnt - start) >= 5, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
